// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor.
// The operand is cut into STAGES slices of WIDTH/STAGES bits. Each stage
// resolves one slice with 4-bit CLA groups and hands its carry to the next
// stage in a register. The upper operand slices that are not yet processed and
// the lower result slices that are already done travel with the transaction.
// A valid/ready handshake with a combinational ready chain lets bubbles
// collapse under backpressure.
module cla_adder_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             OVF,
  output logic             Z
);

  localparam int W  = WIDTH / STAGES;  // slice width
  localparam int NG = W / 4;           // CLA groups per slice

  // Slice adder built from 4-bit lookahead groups. Each group's generate and
  // propagate form its carry-out, which ripples into the next group.
  // Result is {carry_out, sum}.
  function automatic logic [W:0] cla_slice(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic         ci);
    logic [W:0] r;
    logic [3:0] g, p;
    logic       c, c1, c2, c3, gg, pg;
    c = ci;
    r = '0;
    for (int j = 0; j < NG; j++) begin
      g  = a[4*j +: 4] & b[4*j +: 4];
      p  = a[4*j +: 4] ^ b[4*j +: 4];
      c1 = g[0] | (p[0] & c);
      c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
      c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
      gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      pg = &p;
      r[4*j +: 4] = p ^ {c3, c2, c1, c};
      c = gg | (pg & c);
    end
    r[W] = c;
    return r;
  endfunction

  // Subtraction is A + ~B + 1; Cin only matters when adding.
  logic [WIDTH-1:0] beff;
  logic             c0;
  assign beff = SUB ? ~B : B;
  assign c0   = SUB | Cin;

  logic [STAGES-1:0] v_q;   // per-stage valid; the last one is out_valid
  logic [STAGES-1:0] vin;   // valid presented to each stage
  logic [STAGES:0]   rdy;   // stage k may load this cycle

  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q, z_q;

  // Ready chain runs from the output back to the input; it never looks at
  // in_valid, so a full pipeline with a stalled sink refuses new work.
  always_comb begin
    logic r;
    r           = out_ready;
    rdy         = '0;
    rdy[STAGES] = r;
    for (int k = STAGES - 1; k >= 0; k--) begin
      r      = !v_q[k] || r;
      rdy[k] = r;
    end
  end

  // Each stage is fed by the valid of the stage before it.
  always_comb begin
    vin    = '0;
    vin[0] = in_valid;
    for (int k = 1; k < STAGES; k++) vin[k] = v_q[k-1];
  end

  // Valid bits advance whenever their stage is allowed to load; a bubble
  // loaded as a cleared valid is overwritten as soon as work arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++)
        if (rdy[k]) v_q[k] <= vin[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int UW = WIDTH - k * W;  // operand bits still unprocessed
    logic [UW-1:0]        a_in, b_in;
    logic                 c_in;
    logic [W:0]           res;
    logic [(k+1)*W-1:0]   s_next;

    if (k == 0) begin : g_src
      assign a_in   = A;
      assign b_in   = beff;
      assign c_in   = c0;
      assign s_next = res[W-1:0];
    end else begin : g_src
      assign a_in   = stg[k-1].g_reg.a_q;
      assign b_in   = stg[k-1].g_reg.b_q;
      assign c_in   = stg[k-1].g_reg.c_q;
      assign s_next = {res[W-1:0], stg[k-1].g_reg.s_q};
    end

    assign res = cla_slice(a_in[W-1:0], b_in[W-1:0], c_in);

    if (k < STAGES - 1) begin : g_reg
      logic [UW-W-1:0]    a_q, b_q;
      logic [(k+1)*W-1:0] s_q;
      logic               c_q;
      // Stage boundary k: keep upper operand slices, finished low sum, carry.
      always_ff @(posedge clk) begin
        if (rdy[k] && vin[k]) begin
          a_q <= a_in[UW-1:W];
          b_q <= b_in[UW-1:W];
          s_q <= s_next;
          c_q <= res[W];
        end
      end
    end else begin : g_out
      // Carry into the MSB equals a^b^s at that bit, so no extra tap is needed.
      logic ovf_d;
      assign ovf_d = (a_in[W-1] ^ b_in[W-1] ^ res[W-1]) ^ res[W];
      // Final stage boundary: result and flags, held while the sink stalls.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_q  <= '0;
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
          z_q    <= 1'b0;
        end else if (rdy[k] && vin[k]) begin
          sum_q  <= s_next;
          cout_q <= res[W];
          ovf_q  <= ovf_d;
          z_q    <= ~|s_next;
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[STAGES-1];
  assign S         = sum_q;
  assign Cout      = cout_q;
  assign OVF       = ovf_q;
  assign Z         = z_q;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Bench for cla_adder_pipe: a 16-bit/4-stage instance for the directed and
// streaming scenarios, plus 8-bit instances with 1 and 2 stages for soaks.
module tb_cla_adder_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, Cin, SUB, out_valid, out_ready, Cout, OVF, Z;
  logic [15:0] A, B, S;

  cla_adder_pipe #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .SUB(SUB), .out_valid(out_valid),
    .out_ready(out_ready), .S(S), .Cout(Cout), .OVF(OVF), .Z(Z));

  logic [7:0] sA, sB, s1, s2;
  logic       sCin, sSUB;
  logic       v1, r1, ov1, or1, co1, of1, z1;
  logic       v2, r2, ov2, or2, co2, of2, z2;

  cla_adder_pipe #(.WIDTH(8), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1),
    .A(sA), .B(sB), .Cin(sCin), .SUB(sSUB), .out_valid(ov1),
    .out_ready(or1), .S(s1), .Cout(co1), .OVF(of1), .Z(z1));

  cla_adder_pipe #(.WIDTH(8), .STAGES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2),
    .A(sA), .B(sB), .Cin(sCin), .SUB(sSUB), .out_valid(ov2),
    .out_ready(or2), .S(s2), .Cout(co2), .OVF(of2), .Z(z2));

  int checks   = 0;
  int failures = 0;
  logic [18:0] exp_q[$];   // {Z, OVF, Cout, S[15:0]}

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic logic [18:0] model(input int w, input int a, input int b,
                                        input logic ci, input logic su);
    int   half, full, sa, sb, u, sr;
    logic co, ov;
    half = 1 << (w - 1);
    full = 1 << w;
    sa = (a >= half) ? a - full : a;
    sb = (b >= half) ? b - full : b;
    if (!su) begin
      u  = a + b + int'(ci);
      co = (u >= full);
      sr = sa + sb + int'(ci);
    end else begin
      u  = a - b;
      co = (a >= b);
      sr = sa - sb;
      if (u < 0) u = u + full;
    end
    u  = u % full;
    ov = (sr >= half) || (sr < -half);
    return {(u == 0), ov, co, u[15:0]};
  endfunction

  // One cycle on the 16-bit instance; starts and ends just after a falling edge.
  task automatic tick(input logic v, input logic [15:0] a, input logic [15:0] b,
                      input logic ci, input logic su, input logic ordy,
                      output logic acc, output logic got, output logic ov,
                      output logic [18:0] obs);
    in_valid = v; A = a; B = b; Cin = ci; SUB = su; out_ready = ordy;
    #1;
    acc = v && in_ready;
    got = out_valid && ordy;
    ov  = out_valid;
    obs = {Z, OVF, Cout, S};
    if (acc) exp_q.push_back(model(16, int'(a), int'(b), ci, su));
    @(negedge clk);
  endtask

  // One cycle on an 8-bit instance (sel 1 or 2); the other one idles.
  task automatic tick8(input int sel, input logic v, input logic [7:0] a,
                       input logic [7:0] b, input logic ci, input logic su,
                       input logic ordy, output logic acc, output logic got,
                       output logic [18:0] obs);
    sA = a; sB = b; sCin = ci; sSUB = su;
    v1 = (sel == 1) && v; or1 = (sel == 1) ? ordy : 1'b1;
    v2 = (sel == 2) && v; or2 = (sel == 2) ? ordy : 1'b1;
    #1;
    if (sel == 1) begin
      acc = v && r1; got = ov1 && ordy; obs = {z1, of1, co1, 8'h00, s1};
    end else begin
      acc = v && r2; got = ov2 && ordy; obs = {z2, of2, co2, 8'h00, s2};
    end
    if (acc) exp_q.push_back(model(8, int'(a), int'(b), ci, su));
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic acc, got, ov;
    logic [18:0] obs;
    int n;
    checks++;
    if ({out_valid, S, Cout, OVF, Z} !== 20'h0) begin
      failures++;
      $display("FAIL reset_hold got=%h want=0", {out_valid, S, Cout, OVF, Z});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    for (int i = 0; i < 4; i++)
      tick(1'b1, 16'hFFFF, 16'(i + 2), 1'b0, 1'b0, 1'b0, acc, got, ov, obs);
    checks++;
    if (out_valid !== 1'b1 || S !== 16'h0001 || Cout !== 1'b1) begin
      failures++;
      $display("FAIL reset_prefill got v=%b S=%h C=%b want v=1 S=0001 C=1", out_valid, S, Cout);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, S, Cout, OVF, Z} !== 20'h0) begin
      failures++;
      $display("FAIL reset_async got=%h want=0", {out_valid, S, Cout, OVF, Z});
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    n = 0;
    repeat (8) begin
      tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc, got, ov, obs);
      if (ov) n++;
    end
    checks++;
    if (n !== 0) begin
      failures++; $display("FAIL reset_flush got=%0d results want=0", n);
    end
  endtask

  task automatic test_add_wrap();
    logic acc, got, ov;
    logic [18:0] obs;
    int lat;
    tick(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, acc, got, ov, obs);
    got = 1'b0; lat = 0;
    while (!got && lat < 12) begin
      tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc, got, ov, obs);
      lat++;
    end
    checks++;
    if (!got || obs !== {1'b1, 1'b0, 1'b1, 16'h0000}) begin
      failures++;
      $display("FAIL add_wrap got=%h (seen=%b) want=%h", obs, got, {1'b1, 1'b0, 1'b1, 16'h0000});
    end
    checks++;
    if (lat !== 4) begin
      failures++; $display("FAIL add_latency got=%0d want=4", lat);
    end
    exp_q.delete();
  endtask

  task automatic test_sub();
    logic acc, got, ov;
    logic [18:0] obs;
    logic [18:0] res[2];
    int n, cyc;
    tick(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, acc, got, ov, obs);
    tick(1'b1, 16'h0003, 16'h0005, 1'b1, 1'b1, 1'b1, acc, got, ov, obs);
    n = 0; cyc = 0;
    while (n < 2 && cyc < 12) begin
      tick(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc, got, ov, obs);
      if (got) begin res[n] = obs; n++; end
      cyc++;
    end
    checks++;
    if (n !== 2 || res[0] !== {1'b0, 1'b1, 1'b1, 16'h7FFF}) begin
      failures++;
      $display("FAIL sub_ovf got=%h n=%0d want=%h", res[0], n, {1'b0, 1'b1, 1'b1, 16'h7FFF});
    end
    checks++;
    if (n !== 2 || res[1] !== {1'b0, 1'b0, 1'b0, 16'hFFFE}) begin
      failures++;
      $display("FAIL sub_borrow got=%h n=%0d want=%h", res[1], n, {1'b0, 1'b0, 1'b0, 16'hFFFE});
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic acc, got, ov;
    logic [18:0] obs, e;
    int sent, rcvd, cyc, first, last;
    sent = 0; rcvd = 0; cyc = 0; first = -1; last = -1;
    exp_q.delete();
    while (rcvd < 8 && cyc < 40) begin
      tick(sent < 8, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
           1'b1, acc, got, ov, obs);
      if (sent < 8) begin
        checks++;
        if (!acc) begin failures++; $display("FAIL b2b_accept got=0 want=1 at %0d", sent); end
      end
      if (acc) sent++;
      if (got) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin failures++; $display("FAIL b2b_result[%0d] got=%h want=%h", rcvd, obs, e); end
        if (first < 0) first = cyc;
        last = cyc;
        rcvd++;
      end
      cyc++;
    end
    checks++;
    if (rcvd !== 8 || last - first !== 7) begin
      failures++;
      $display("FAIL b2b_spacing got n=%0d span=%0d want n=8 span=7", rcvd, last - first);
    end
  endtask

  task automatic test_backpressure();
    logic acc, got, ov, have;
    logic [18:0] obs, held, e;
    logic [15:0] a, b;
    logic ci, su;
    int sent, rcvd, cyc;
    exp_q.delete();
    a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); su = 1'($urandom);
    sent = 0; have = 1'b0; held = '0;
    for (int t = 0; t < 6; t++) begin
      tick(1'b1, a, b, ci, su, 1'b0, acc, got, ov, obs);
      if (acc) begin
        sent++;
        a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); su = 1'($urandom);
      end
      if (ov) begin
        if (!have) begin held = obs; have = 1'b1; end
        else begin
          checks++;
          if (obs !== held) begin failures++; $display("FAIL bp_hold got=%h want=%h", obs, held); end
        end
      end
    end
    checks++;
    if (sent !== 4 || in_ready !== 1'b0) begin
      failures++; $display("FAIL bp_fill got accepts=%0d in_ready=%b want 4 and 0", sent, in_ready);
    end
    checks++;
    if (!have || held !== exp_q[0]) begin
      failures++; $display("FAIL bp_head got=%h want=%h", held, exp_q[0]);
    end
    rcvd = 0; cyc = 0;
    while (rcvd < 10 && cyc < 50) begin
      tick(sent < 10, a, b, ci, su, 1'b1, acc, got, ov, obs);
      if (acc) begin
        sent++;
        a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); su = 1'($urandom);
      end
      if (got) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL bp_extra got=%h want none", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin failures++; $display("FAIL bp_result[%0d] got=%h want=%h", rcvd, obs, e); end
        end
        rcvd++;
      end
      cyc++;
    end
    checks++;
    if (rcvd !== 10 || exp_q.size() !== 0) begin
      failures++; $display("FAIL bp_count got=%0d left=%0d want 10 and 0", rcvd, exp_q.size());
    end
  endtask

  task automatic test_soak(input int sel);
    logic acc, got;
    logic [18:0] obs, e;
    logic [7:0] a, b;
    logic ci, su;
    int sent, rcvd, cyc, bad;
    exp_q.delete();
    a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom); su = 1'($urandom);
    sent = 0; rcvd = 0; cyc = 0; bad = 0;
    while ((sent < 1000 || rcvd < sent) && cyc < 20000) begin
      tick8(sel, (sent < 1000) && ($urandom_range(0, 3) != 0), a, b, ci, su,
            $urandom_range(0, 2) != 0, acc, got, obs);
      if (acc) begin
        sent++;
        a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom); su = 1'($urandom);
      end
      if (got) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL soak%0d_extra got=%h want none", sel, obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            failures++;
            if (bad < 10) $display("FAIL soak%0d_result[%0d] got=%h want=%h", sel, rcvd, obs, e);
            bad++;
          end
        end
        rcvd++;
      end
      cyc++;
    end
    checks++;
    if (sent !== 1000 || rcvd !== 1000) begin
      failures++; $display("FAIL soak%0d_count got sent=%0d rcvd=%0d want 1000", sel, sent, rcvd);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout got=hang want=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; SUB = 1'b0; out_ready = 1'b1;
    sA = '0; sB = '0; sCin = 1'b0; sSUB = 1'b0;
    v1 = 1'b0; v2 = 1'b0; or1 = 1'b1; or2 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_add_wrap();
    test_sub();
    test_back_to_back();
    test_backpressure();
    test_soak(1);
    test_soak(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
